// File: rtl/lms_spi_pkg.sv
// Shared register map, frame helpers and sequencer state encoding for the
// LMS7 SPI command path.
package lms_spi_pkg;

    localparam logic [2:0] REG_RXDATA  = 3'd0;
    localparam logic [2:0] REG_TXDATA  = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_CONTROL = 3'd3;
    localparam logic [2:0] REG_SLVSEL  = 3'd5;

    localparam int          SSO_BIT     = 10;
    localparam logic [15:0] SSO_ON_DATA = 16'h0001 << SSO_BIT;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CLR     = 4'd1,
        ST_SEL     = 4'd2,
        ST_SSO_ON  = 4'd3,
        ST_TX_WAIT = 4'd4,
        ST_TX_WR   = 4'd5,
        ST_RX_WAIT = 4'd6,
        ST_RX_RD   = 4'd7,
        ST_SSO_OFF = 4'd8,
        ST_RSP     = 4'd9
    } seq_state_t;

    // Byte idx of the 4-byte LMS7 frame; data bytes are zero for reads.
    function automatic logic [7:0] frame_byte(input logic [1:0]  idx,
                                              input logic        wr,
                                              input logic [14:0] addr,
                                              input logic [15:0] wdata);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {wr, addr[14:8]};
            2'd1:    b = addr[7:0];
            2'd2:    b = wr ? wdata[15:8] : 8'h00;
            2'd3:    b = wr ? wdata[7:0]  : 8'h00;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lms_spi_bus_op.sv
// Single register-port access to the SPI core: two strobe cycles followed by
// one mandatory idle cycle, with done pulsed during the idle cycle.
module lms_spi_bus_op (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [15:0] wdata,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        spi_select,
    output logic [2:0]  spi_mem_addr,
    output logic [15:0] spi_data_out,
    output logic        spi_write_n,
    output logic        spi_read_n,
    input  logic [15:0] spi_data_in
);

    logic [1:0]  phase_r;
    logic        done_r;
    logic [7:0]  rdata_r;
    logic        select_r;
    logic [2:0]  mem_addr_r;
    logic [15:0] data_out_r;
    logic        write_n_r;
    logic        read_n_r;

    // Only the low byte of RXDATA carries SPI data.
    logic unused_hi_s;
    assign unused_hi_s = ^spi_data_in[15:8];

    // Access phase sequencer: 0 idle, 1-2 strobe active, 3 idle gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_r    <= 2'd0;
            done_r     <= 1'b0;
            rdata_r    <= 8'h00;
            select_r   <= 1'b0;
            mem_addr_r <= 3'd0;
            data_out_r <= 16'h0000;
            write_n_r  <= 1'b1;
            read_n_r   <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (phase_r)
                2'd0: begin
                    if (start) begin
                        phase_r    <= 2'd1;
                        select_r   <= 1'b1;
                        mem_addr_r <= addr;
                        data_out_r <= wdata;
                        write_n_r  <= ~we;
                        read_n_r   <= we;
                    end else begin
                        phase_r <= 2'd0;
                    end
                end
                2'd1: phase_r <= 2'd2;
                2'd2: begin
                    phase_r   <= 2'd3;
                    select_r  <= 1'b0;
                    write_n_r <= 1'b1;
                    read_n_r  <= 1'b1;
                    done_r    <= 1'b1;
                    if (!read_n_r) begin
                        rdata_r <= spi_data_in[7:0];
                    end else begin
                        rdata_r <= rdata_r;
                    end
                end
                2'd3:    phase_r <= 2'd0;
                default: phase_r <= 2'd0;
            endcase
        end
    end

    assign done         = done_r;
    assign rdata        = rdata_r;
    assign spi_select   = select_r;
    assign spi_mem_addr = mem_addr_r;
    assign spi_data_out = data_out_r;
    assign spi_write_n  = write_n_r;
    assign spi_read_n   = read_n_r;

endmodule

// File: rtl/lms_spi_cmd_seq.sv
// Turns one LMS7 register command into a 4-byte SPI frame on the SPI core's
// register port, holding SS via SSO, and returns bytes 3/4 as read data.
module lms_spi_cmd_seq
    import lms_spi_pkg::*;
#(
    parameter  int TIMEOUT_CYCLES = 4095,
    parameter  int NUM_SLAVES     = 2,
    localparam int SLV_W          = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_wr,
    input  logic [14:0]      cmd_addr,
    input  logic [15:0]      cmd_wdata,
    input  logic [SLV_W-1:0] cmd_slave,
    output logic             rsp_valid,
    output logic [15:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             spi_select,
    output logic [2:0]       spi_mem_addr,
    output logic [15:0]      spi_data_out,
    output logic             spi_write_n,
    output logic             spi_read_n,
    input  logic [15:0]      spi_data_in,
    input  logic             spi_readyfordata,
    input  logic             spi_dataavailable
);

    localparam logic [11:0] WAIT_LIM = 12'(TIMEOUT_CYCLES - 1);

    seq_state_t       state_r;
    logic             op_start_r;
    logic             wr_r;
    logic [14:0]      addr_r;
    logic [15:0]      wdata_r;
    logic [SLV_W-1:0] slave_r;
    logic [1:0]       byte_cnt_r;
    logic [11:0]      wait_cnt_r;
    logic             abort_r;
    logic [7:0]       rx_hi_r;
    logic [7:0]       rx_lo_r;
    logic             cmd_ready_r;
    logic             rsp_valid_r;
    logic             rsp_err_r;
    logic [15:0]      rsp_rdata_r;

    logic             op_we_s;
    logic [2:0]       op_addr_s;
    logic [15:0]      op_wdata_s;
    logic             op_done_s;
    logic [7:0]       op_rdata_s;

    // Register access implied by the current state; sampled by the bus op on start.
    always_comb begin
        op_we_s    = 1'b1;
        op_addr_s  = REG_STATUS;
        op_wdata_s = 16'h0000;
        case (state_r)
            ST_SEL: begin
                op_addr_s  = REG_SLVSEL;
                op_wdata_s = 16'h0001 << slave_r;
            end
            ST_SSO_ON: begin
                op_addr_s  = REG_CONTROL;
                op_wdata_s = SSO_ON_DATA;
            end
            ST_TX_WR: begin
                op_addr_s  = REG_TXDATA;
                op_wdata_s = {8'h00, frame_byte(byte_cnt_r, wr_r, addr_r, wdata_r)};
            end
            ST_RX_RD: begin
                op_we_s   = 1'b0;
                op_addr_s = REG_RXDATA;
            end
            ST_SSO_OFF: begin
                op_addr_s  = REG_CONTROL;
                op_wdata_s = 16'h0000;
            end
            default: begin
                op_addr_s = REG_STATUS;
            end
        endcase
    end

    // Command sequencer; op_start_r pulses in the first cycle of every bus-op state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            op_start_r  <= 1'b0;
            wr_r        <= 1'b0;
            addr_r      <= 15'h0000;
            wdata_r     <= 16'h0000;
            slave_r     <= '0;
            byte_cnt_r  <= 2'd0;
            wait_cnt_r  <= 12'd0;
            abort_r     <= 1'b0;
            rx_hi_r     <= 8'h00;
            rx_lo_r     <= 8'h00;
            cmd_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 16'h0000;
        end else begin
            op_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_r) begin
                        wr_r        <= cmd_wr;
                        addr_r      <= cmd_addr;
                        wdata_r     <= cmd_wdata;
                        slave_r     <= cmd_slave;
                        byte_cnt_r  <= 2'd0;
                        abort_r     <= 1'b0;
                        rx_hi_r     <= 8'h00;
                        rx_lo_r     <= 8'h00;
                        cmd_ready_r <= 1'b0;
                        op_start_r  <= 1'b1;
                        state_r     <= ST_CLR;
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                ST_CLR: if (op_done_s) begin
                    op_start_r <= 1'b1;
                    state_r    <= ST_SEL;
                end
                ST_SEL: if (op_done_s) begin
                    op_start_r <= 1'b1;
                    state_r    <= ST_SSO_ON;
                end
                ST_SSO_ON: if (op_done_s) begin
                    wait_cnt_r <= 12'd0;
                    state_r    <= ST_TX_WAIT;
                end
                ST_TX_WAIT: begin
                    if (spi_readyfordata) begin
                        op_start_r <= 1'b1;
                        state_r    <= ST_TX_WR;
                    end else if (wait_cnt_r == WAIT_LIM) begin
                        abort_r    <= 1'b1;
                        op_start_r <= 1'b1;
                        state_r    <= ST_SSO_OFF;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 12'd1;
                    end
                end
                ST_TX_WR: if (op_done_s) begin
                    wait_cnt_r <= 12'd0;
                    state_r    <= ST_RX_WAIT;
                end
                ST_RX_WAIT: begin
                    if (spi_dataavailable) begin
                        op_start_r <= 1'b1;
                        state_r    <= ST_RX_RD;
                    end else if (wait_cnt_r == WAIT_LIM) begin
                        abort_r    <= 1'b1;
                        op_start_r <= 1'b1;
                        state_r    <= ST_SSO_OFF;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 12'd1;
                    end
                end
                ST_RX_RD: if (op_done_s) begin
                    if (byte_cnt_r == 2'd2) rx_hi_r <= op_rdata_s;
                    if (byte_cnt_r == 2'd3) begin
                        rx_lo_r    <= op_rdata_s;
                        op_start_r <= 1'b1;
                        state_r    <= ST_SSO_OFF;
                    end else begin
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        wait_cnt_r <= 12'd0;
                        state_r    <= ST_TX_WAIT;
                    end
                end
                ST_SSO_OFF: if (op_done_s) begin
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= abort_r;
                    rsp_rdata_r <= {rx_hi_r, rx_lo_r};
                    state_r     <= ST_RSP;
                end
                ST_RSP: begin
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    lms_spi_bus_op u_bus_op (
        .clk          (clk),
        .reset        (reset),
        .start        (op_start_r),
        .we           (op_we_s),
        .addr         (op_addr_s),
        .wdata        (op_wdata_s),
        .done         (op_done_s),
        .rdata        (op_rdata_s),
        .spi_select   (spi_select),
        .spi_mem_addr (spi_mem_addr),
        .spi_data_out (spi_data_out),
        .spi_write_n  (spi_write_n),
        .spi_read_n   (spi_read_n),
        .spi_data_in  (spi_data_in)
    );

    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_lms_spi_cmd_seq.sv
// Directed bench for lms_spi_cmd_seq with a behavioural SPI core register-port
// model that logs every bus op and checks strobe shape and TRDY discipline.
module tb_lms_spi_cmd_seq;

    localparam int TO = 4095;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [14:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic [0:0]  cmd_slave;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic        spi_select, spi_write_n, spi_read_n;
    logic [2:0]  spi_mem_addr;
    logic [15:0] spi_data_out;
    logic [15:0] spi_data_in = 16'h0000;
    logic        spi_readyfordata = 1'b1;
    logic        spi_dataavailable = 1'b0;

    lms_spi_cmd_seq #(.TIMEOUT_CYCLES(TO), .NUM_SLAVES(2)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_slave(cmd_slave),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .spi_select(spi_select), .spi_mem_addr(spi_mem_addr),
        .spi_data_out(spi_data_out), .spi_write_n(spi_write_n),
        .spi_read_n(spi_read_n), .spi_data_in(spi_data_in),
        .spi_readyfordata(spi_readyfordata), .spi_dataavailable(spi_dataavailable)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model configuration, written only by the stimulus process.
    int         trdy_delay = 0;
    int         dav_limit  = 4;
    logic [7:0] rx_tab [0:3];

    // Core model state, written only by the model process.
    logic [19:0] op_log [0:255];
    int          op_n = 0, pulse_len = 0, pulse_bad = 0, stable_bad = 0, trdy_bad = 0;
    int          tx_n = 0, rx_idx = 0, trdy_cnt = 0;
    logic        cur_we, act, dav = 1'b0;
    logic [2:0]  cur_addr;
    logic [15:0] cur_data;

    // SPI core register-port model, evaluated on the falling edge.
    always @(negedge clk) begin
        act = !spi_write_n || !spi_read_n;
        if (act) begin
            if (pulse_len == 0) begin
                cur_we   = !spi_write_n;
                cur_addr = spi_mem_addr;
                cur_data = spi_data_out;
                op_log[op_n % 256] = {cur_we, cur_addr,
                                      (cur_we && cur_addr != 3'd2) ? cur_data : 16'h0000};
                op_n = op_n + 1;
                if (!spi_select) stable_bad = stable_bad + 1;
                if (cur_we && cur_addr == 3'd1) begin
                    if (!spi_readyfordata) trdy_bad = trdy_bad + 1;
                    tx_n = tx_n + 1;
                end
                if (cur_we && cur_addr == 3'd2) begin
                    tx_n   = 0;
                    rx_idx = 0;
                end
            end else if (!spi_select || spi_mem_addr != cur_addr || spi_data_out != cur_data
                         || spi_write_n != !cur_we || spi_read_n != cur_we) begin
                stable_bad = stable_bad + 1;
            end
            pulse_len = pulse_len + 1;
        end else if (pulse_len != 0) begin
            if (pulse_len != 2) pulse_bad = pulse_bad + 1;
            pulse_len = 0;
            if (cur_we && cur_addr == 3'd1) begin
                trdy_cnt = trdy_delay;
                if (tx_n <= dav_limit) dav = 1'b1;
            end
            if (cur_we && cur_addr == 3'd3 && cur_data == 16'h0400) trdy_cnt = trdy_delay;
            if (!cur_we && cur_addr == 3'd0) begin
                dav    = 1'b0;
                rx_idx = rx_idx + 1;
            end
        end else if (trdy_cnt > 0) begin
            trdy_cnt = trdy_cnt - 1;
        end
        spi_readyfordata  = (trdy_cnt == 0);
        spi_dataavailable = dav;
        spi_data_in       = {8'h00, rx_tab[rx_idx % 4]};
    end

    int          n_checks = 0, n_errors = 0;
    int          cmd_base, t_acc, elapsed;
    logic [15:0] got_rdata;
    logic        got_err;
    logic [19:0] exp_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] wop(input logic [2:0] a, input logic [15:0] d);
        return {1'b1, a, d};
    endfunction

    // Expected op list: CLR, SEL, SSO on, n_tx byte writes (first n_rd read back), SSO off.
    task automatic build_exp(input logic [15:0] sel, input logic [31:0] bytes,
                             input int n_tx, input int n_rd);
        exp_q = {};
        exp_q.push_back(wop(3'd2, 16'h0000));
        exp_q.push_back(wop(3'd5, sel));
        exp_q.push_back(wop(3'd3, 16'h0400));
        for (int i = 0; i < n_tx; i++) begin
            exp_q.push_back(wop(3'd1, {8'h00, bytes[31-8*i -: 8]}));
            if (i < n_rd) exp_q.push_back(20'h00000);
        end
        exp_q.push_back(wop(3'd3, 16'h0000));
    endtask

    task automatic cmp_ops(input string tag, input int base);
        check_val({tag, "_nops"}, 32'(op_n - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check_val($sformatf("%s_op%0d", tag, i), 32'(op_log[(base + i) % 256]), 32'(exp_q[i]));
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (cmd_ready) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check_val("ready_wait", 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check_val("rsp_seen", 32'(seen), 32'd1);
        if (seen) begin
            got_rdata = rsp_rdata;
            got_err   = rsp_err;
            elapsed   = cyc - t_acc;
            check_val("rdy_in_rsp", 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
            check_val("rsp_pulse", 32'({rsp_valid, cmd_ready}), 32'b01);
        end
    endtask

    task automatic issue(input logic wr, input logic [14:0] a, input logic [15:0] d, input logic [0:0] s);
        wait_ready();
        cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_slave = s;
        cmd_valid = 1'b1;
        cmd_base = op_n;
        t_acc = cyc;
        @(posedge clk); #1;
    endtask

    task automatic do_cmd(input logic wr, input logic [14:0] a, input logic [15:0] d,
                          input logic [0:0] s, input int budget);
        issue(wr, a, d, s);
        cmd_valid = 1'b0;
        wait_rsp(budget);
    endtask

    initial begin
        int  b1, pb0, sb0, tb0, rsp_cnt;
        bit  found;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 15'h0; cmd_wdata = 16'h0; cmd_slave = 1'b0;
        rx_tab[0] = 8'h11; rx_tab[1] = 8'h22; rx_tab[2] = 8'h33; rx_tab[3] = 8'h44;

        #13;
        check_val("rst_ctrl", 32'({cmd_ready, rsp_valid, rsp_err, spi_select, spi_write_n, spi_read_n}),
                  32'b000011);
        check_val("rst_rdata", 32'(rsp_rdata), 32'h0);
        check_val("rst_bus", 32'({spi_mem_addr, spi_data_out}), 32'h0);
        #9 reset = 1'b0;
        #1 check_val("rdy_pre", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check_val("rdy_post", 32'(cmd_ready), 32'd1);

        // Write slave0 addr 0x0020 data 0x1234
        do_cmd(1'b1, 15'h0020, 16'h1234, 1'b0, 500);
        check_val("wr_err", 32'(got_err), 32'd0);
        check_val("wr_rdata", 32'(got_rdata), 32'h3344);
        build_exp(16'h0001, 32'h80201234, 4, 4);
        cmp_ops("wr", cmd_base);

        // Read slave1 addr 0x002F
        rx_tab[0] = 8'h00; rx_tab[1] = 8'h00; rx_tab[2] = 8'hAB; rx_tab[3] = 8'hCD;
        do_cmd(1'b0, 15'h002F, 16'hFFFF, 1'b1, 500);
        check_val("rd_err", 32'(got_err), 32'd0);
        check_val("rd_rdata", 32'(got_rdata), 32'hABCD);
        build_exp(16'h0002, 32'h002F0000, 4, 4);
        cmp_ops("rd", cmd_base);

        // RRDY withheld after byte 2 forces a timeout
        dav_limit = 2;
        do_cmd(1'b1, 15'h0020, 16'h1234, 1'b0, TO + 500);
        dav_limit = 4;
        check_val("to_err", 32'(got_err), 32'd1);
        check_val("to_time", 32'(elapsed >= TO && elapsed < TO + 100), 32'd1);
        build_exp(16'h0001, 32'h80201234, 3, 2);
        cmp_ops("to", cmd_base);

        // Back-to-back with cmd_valid held high
        issue(1'b1, 15'h0020, 16'h1234, 1'b0);
        b1 = cmd_base;
        cmd_wr = 1'b0; cmd_addr = 15'h002F; cmd_wdata = 16'h0000; cmd_slave = 1'b1;
        wait_rsp(500);
        build_exp(16'h0001, 32'h80201234, 4, 4);
        cmp_ops("b2b_a", b1);
        cmd_base = op_n;
        t_acc = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_val("b2b_acc", 32'(cmd_ready), 32'd0);
        wait_rsp(500);
        check_val("b2b_rdata", 32'(got_rdata), 32'hABCD);
        build_exp(16'h0002, 32'h002F0000, 4, 4);
        cmp_ops("b2b_b", cmd_base);
        check_val("pulse_len", 32'(pulse_bad), 32'd0);
        check_val("op_stable", 32'(stable_bad), 32'd0);

        // TRDY delayed 50 cycles per byte
        rx_tab[0] = 8'h11; rx_tab[1] = 8'h22; rx_tab[2] = 8'h33; rx_tab[3] = 8'h44;
        trdy_delay = 50;
        pb0 = pulse_bad; sb0 = stable_bad; tb0 = trdy_bad;
        do_cmd(1'b1, 15'h0020, 16'h1234, 1'b0, 2000);
        trdy_delay = 0;
        check_val("trdy_wr", 32'(trdy_bad - tb0), 32'd0);
        check_val("trdy_time", 32'(elapsed >= 200), 32'd1);
        check_val("trdy_rdata", 32'(got_rdata), 32'h3344);
        check_val("trdy_shape", 32'((pulse_bad - pb0) + (stable_bad - sb0)), 32'd0);
        build_exp(16'h0001, 32'h80201234, 4, 4);
        cmp_ops("trdy", cmd_base);

        // Reset during the TXDATA write of byte 2
        issue(1'b1, 15'h0020, 16'h1234, 1'b0);
        cmd_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (!spi_write_n && spi_mem_addr == 3'd1 && spi_data_out == 16'h0020) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check_val("mid_found", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1 check_val("mid_rst_bus", 32'({spi_write_n, spi_select, cmd_ready}), 32'b100);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1 check_val("mid_rdy_pre", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check_val("mid_rdy_post", 32'(cmd_ready), 32'd1);
        rsp_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid || spi_select) rsp_cnt = rsp_cnt + 1;
            @(posedge clk); #1;
        end
        check_val("mid_quiet", 32'(rsp_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
